recv_inference: RTL and testbench

- Receive-side counterpart of send_inference: accepts inference-result payloads arriving on the TCP receive streams and writes them into a host ring buffer over the DMA write command/data streams.
- Sits behind the TCP rx demux on path 1, alongside send_inference. Controlled by a small register slice and reports progress counters for the status registers.

---
 rtl/recv_inference.sv | 254 +++++++++++++++++++++++++
 tb/tb_recv_inference.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/recv_inference.sv
// Receive-side inference path: takes rx payloads from the TCP demux and writes
// them into a host ring buffer through the DMA write command/data streams.
module recv_inference #(
  parameter int          DATA_WIDTH  = 512,
  parameter logic [15:0] MAX_PKT_LEN = 16'd4096
) (
  input  logic                    clk,
  input  logic                    rstn,

  input  logic                    s_axis_rx_metadata_valid,
  output logic                    s_axis_rx_metadata_ready,
  input  logic [87:0]             s_axis_rx_metadata_data,

  input  logic                    s_axis_rx_data_valid,
  output logic                    s_axis_rx_data_ready,
  input  logic [DATA_WIDTH-1:0]   s_axis_rx_data_data,
  input  logic [DATA_WIDTH/8-1:0] s_axis_rx_data_keep,
  input  logic                    s_axis_rx_data_last,

  output logic                    m_axis_dma_write_cmd_valid,
  input  logic                    m_axis_dma_write_cmd_ready,
  output logic [63:0]             m_axis_dma_write_cmd_address,
  output logic [31:0]             m_axis_dma_write_cmd_length,

  output logic                    m_axis_dma_write_data_valid,
  input  logic                    m_axis_dma_write_data_ready,
  output logic [DATA_WIDTH-1:0]   m_axis_dma_write_data_data,
  output logic [DATA_WIDTH/8-1:0] m_axis_dma_write_data_keep,
  output logic                    m_axis_dma_write_data_last,

  input  logic                    ctrl_start,
  input  logic [63:0]             ctrl_base_addr,
  input  logic [31:0]             ctrl_ring_len,
  input  logic [31:0]             ctrl_total_len,

  output logic [31:0]             stat_bytes,
  output logic [31:0]             stat_pkts,
  output logic [31:0]             stat_err,
  output logic                    stat_done
);

  localparam int          KEEP_WIDTH = DATA_WIDTH / 8;
  localparam int          BEAT_SHIFT = $clog2(KEEP_WIDTH);
  localparam logic [31:0] BEAT_ADD   = 32'(KEEP_WIDTH - 1);
  localparam logic [31:0] BEAT_MASK  = ~BEAT_ADD;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    META  = 3'd1,
    CMD   = 3'd2,
    DATA  = 3'd3,
    DRAIN = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t      state_r;
  state_t      state_nxt_s;

  logic        start_d_r;
  logic [63:0] base_r;
  logic [31:0] ring_len_r;
  logic [31:0] total_len_r;
  logic [31:0] offset_r;
  logic [15:0] len_r;
  logic [15:0] beat_cnt_r;

  logic        start_edge_s;
  logic        start_acc_s;
  logic        meta_hs_s;
  logic        cmd_hs_s;
  logic        beat_hs_s;
  logic        last_beat_s;
  logic        pkt_end_s;
  logic        err_inc_s;

  logic [15:0] meta_len_s;
  logic        len_bad_s;
  logic        wrap_s;
  logic [31:0] offset_sel_s;
  logic [31:0] len_round_s;
  logic [31:0] beats_total_s;
  logic [31:0] bytes_next_s;
  logic        unused_bits_s;

  // Derived packet arithmetic shared by the FSM and the datapath registers.
  always_comb begin
    start_edge_s  = ctrl_start & ~start_d_r;
    meta_len_s    = s_axis_rx_metadata_data[31:16];
    len_bad_s     = (meta_len_s == 16'd0) || (meta_len_s > MAX_PKT_LEN);
    wrap_s        = ({1'b0, offset_r} + {17'd0, meta_len_s}) > {1'b0, ring_len_r};
    if (wrap_s) begin
      offset_sel_s = 32'd0;
    end else begin
      offset_sel_s = offset_r;
    end
    len_round_s   = ({16'd0, len_r} + BEAT_ADD) & BEAT_MASK;
    beats_total_s = len_round_s >> BEAT_SHIFT;
    last_beat_s   = ({16'd0, beat_cnt_r} == beats_total_s);
    bytes_next_s  = stat_bytes + {16'd0, len_r};
    unused_bits_s = ^{s_axis_rx_metadata_data[87:32], s_axis_rx_metadata_data[15:0]};
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic, stream handshakes and the DATA-state pass-through.
  always_comb begin
    state_nxt_s                 = state_r;
    start_acc_s                 = 1'b0;
    meta_hs_s                   = 1'b0;
    cmd_hs_s                    = 1'b0;
    beat_hs_s                   = 1'b0;
    pkt_end_s                   = 1'b0;
    err_inc_s                   = 1'b0;
    s_axis_rx_metadata_ready    = 1'b0;
    s_axis_rx_data_ready        = 1'b0;
    m_axis_dma_write_cmd_valid  = 1'b0;
    m_axis_dma_write_data_valid = 1'b0;
    m_axis_dma_write_data_data  = {DATA_WIDTH{1'b0}};
    m_axis_dma_write_data_keep  = {KEEP_WIDTH{1'b0}};
    m_axis_dma_write_data_last  = 1'b0;
    case (state_r)
      IDLE, DONE: begin
        if (start_edge_s) begin
          start_acc_s = 1'b1;
          state_nxt_s = META;
        end else begin
          state_nxt_s = state_r;
        end
      end
      META: begin
        s_axis_rx_metadata_ready = 1'b1;
        if (s_axis_rx_metadata_valid) begin
          meta_hs_s = 1'b1;
          if (len_bad_s) begin
            err_inc_s   = 1'b1;
            state_nxt_s = DRAIN;
          end else begin
            state_nxt_s = CMD;
          end
        end else begin
          state_nxt_s = META;
        end
      end
      CMD: begin
        m_axis_dma_write_cmd_valid = 1'b1;
        if (m_axis_dma_write_cmd_ready) begin
          cmd_hs_s    = 1'b1;
          state_nxt_s = DATA;
        end else begin
          state_nxt_s = CMD;
        end
      end
      DATA: begin
        // Zero-latency pass-through; last comes from our own beat count.
        s_axis_rx_data_ready        = m_axis_dma_write_data_ready;
        m_axis_dma_write_data_valid = s_axis_rx_data_valid;
        m_axis_dma_write_data_data  = s_axis_rx_data_data;
        m_axis_dma_write_data_keep  = s_axis_rx_data_keep;
        m_axis_dma_write_data_last  = last_beat_s;
        if (s_axis_rx_data_valid && m_axis_dma_write_data_ready) begin
          beat_hs_s = 1'b1;
          err_inc_s = (s_axis_rx_data_last != last_beat_s);
          if (last_beat_s) begin
            pkt_end_s = 1'b1;
            if (bytes_next_s >= total_len_r) begin
              state_nxt_s = DONE;
            end else begin
              state_nxt_s = META;
            end
          end else begin
            state_nxt_s = DATA;
          end
        end else begin
          state_nxt_s = DATA;
        end
      end
      DRAIN: begin
        s_axis_rx_data_ready = 1'b1;
        if (s_axis_rx_data_valid && s_axis_rx_data_last) begin
          state_nxt_s = META;
        end else begin
          state_nxt_s = DRAIN;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Run configuration, ring offset, command fields, beat counter and statistics.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      start_d_r                    <= 1'b0;
      base_r                       <= 64'd0;
      ring_len_r                   <= 32'd0;
      total_len_r                  <= 32'd0;
      offset_r                     <= 32'd0;
      len_r                        <= 16'd0;
      beat_cnt_r                   <= 16'd0;
      m_axis_dma_write_cmd_address <= 64'd0;
      m_axis_dma_write_cmd_length  <= 32'd0;
      stat_bytes                   <= 32'd0;
      stat_pkts                    <= 32'd0;
      stat_err                     <= 32'd0;
      stat_done                    <= 1'b0;
    end else begin
      start_d_r <= ctrl_start;
      if (start_acc_s) begin
        base_r      <= ctrl_base_addr;
        ring_len_r  <= ctrl_ring_len;
        total_len_r <= ctrl_total_len;
        offset_r    <= 32'd0;
        stat_bytes  <= 32'd0;
        stat_pkts   <= 32'd0;
        stat_err    <= 32'd0;
        stat_done   <= 1'b0;
      end else begin
        if (err_inc_s) begin
          stat_err <= stat_err + 32'd1;
        end
        if (meta_hs_s) begin
          len_r      <= meta_len_s;
          beat_cnt_r <= 16'd1;
          if (!len_bad_s) begin
            // Packets never straddle the wrap: restart at the ring base instead.
            offset_r                     <= offset_sel_s;
            m_axis_dma_write_cmd_address <= base_r + {32'd0, offset_sel_s};
            m_axis_dma_write_cmd_length  <= {16'd0, meta_len_s};
          end
        end
        if (beat_hs_s) begin
          beat_cnt_r <= beat_cnt_r + 16'd1;
        end
        if (pkt_end_s) begin
          offset_r   <= offset_r + len_round_s;
          stat_bytes <= bytes_next_s;
          stat_pkts  <= stat_pkts + 32'd1;
          if (bytes_next_s >= total_len_r) begin
            stat_done <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_recv_inference.sv
// Directed self-checking bench for recv_inference: single packet, ring wrap,
// unaligned length, DMA back-pressure, length error drain, restart, mid-packet reset.
module tb_recv_inference;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         meta_valid = 1'b0;
  logic         meta_ready;
  logic [87:0]  meta_data = '0;
  logic         rx_valid = 1'b0;
  logic         rx_ready;
  logic [511:0] rx_data = '0;
  logic [63:0]  rx_keep = '0;
  logic         rx_last = 1'b0;
  logic         cmd_valid;
  logic         cmd_ready = 1'b0;
  logic [63:0]  cmd_addr;
  logic [31:0]  cmd_len;
  logic         dma_valid;
  logic         dma_ready = 1'b0;
  logic [511:0] dma_data;
  logic [63:0]  dma_keep;
  logic         dma_last;
  logic         ctrl_start = 1'b0;
  logic [63:0]  ctrl_base = '0;
  logic [31:0]  ctrl_ring = '0;
  logic [31:0]  ctrl_total = '0;
  logic [31:0]  stat_bytes;
  logic [31:0]  stat_pkts;
  logic [31:0]  stat_err;
  logic         stat_done;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  recv_inference dut (
    .clk                          (clk),
    .rstn                         (rstn),
    .s_axis_rx_metadata_valid     (meta_valid),
    .s_axis_rx_metadata_ready     (meta_ready),
    .s_axis_rx_metadata_data      (meta_data),
    .s_axis_rx_data_valid         (rx_valid),
    .s_axis_rx_data_ready         (rx_ready),
    .s_axis_rx_data_data          (rx_data),
    .s_axis_rx_data_keep          (rx_keep),
    .s_axis_rx_data_last          (rx_last),
    .m_axis_dma_write_cmd_valid   (cmd_valid),
    .m_axis_dma_write_cmd_ready   (cmd_ready),
    .m_axis_dma_write_cmd_address (cmd_addr),
    .m_axis_dma_write_cmd_length  (cmd_len),
    .m_axis_dma_write_data_valid  (dma_valid),
    .m_axis_dma_write_data_ready  (dma_ready),
    .m_axis_dma_write_data_data   (dma_data),
    .m_axis_dma_write_data_keep   (dma_keep),
    .m_axis_dma_write_data_last   (dma_last),
    .ctrl_start                   (ctrl_start),
    .ctrl_base_addr               (ctrl_base),
    .ctrl_ring_len                (ctrl_ring),
    .ctrl_total_len               (ctrl_total),
    .stat_bytes                   (stat_bytes),
    .stat_pkts                    (stat_pkts),
    .stat_err                     (stat_err),
    .stat_done                    (stat_done)
  );

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] pat(input int seed, input int i);
    logic [31:0] w;
    w = 32'(seed * 256 + i);
    return {16{w}};
  endfunction

  function automatic logic [63:0] kpat(input int seed, input int i);
    logic [31:0] w;
    w = 32'(seed + i * 3);
    return {w, ~w};
  endfunction

  task automatic start_run(input logic [63:0] base, input logic [31:0] ring, input logic [31:0] total);
    @(negedge clk);
    ctrl_base = base; ctrl_ring = ring; ctrl_total = total; ctrl_start = 1'b1;
    @(negedge clk);
    ctrl_start = 1'b0;
    chk("start_bytes", stat_bytes, 0);
    chk("start_pkts", stat_pkts, 0);
    chk("start_err", stat_err, 0);
    chk("start_done", stat_done, 0);
    chk("start_meta_ready", meta_ready, 1);
  endtask

  task automatic send_meta(input logic [15:0] len);
    int n = 0;
    @(negedge clk);
    meta_valid = 1'b1;
    meta_data = {56'hA5A5_5A5A_0F0F_F0, len, 16'h1234};
    while (meta_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("meta_wait", (n < 50), 1);
    @(posedge clk);
    #1 meta_valid = 1'b0;
  endtask

  task automatic expect_cmd(input logic [63:0] addr, input logic [31:0] len, input int hold);
    int n = 0;
    @(negedge clk);
    while (cmd_valid !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_wait", (n < 50), 1);
    dma_ready = 1'b1;
    for (int h = 0; h <= hold; h++) begin
      if (h == hold) cmd_ready = 1'b1;
      chk("cmd_valid", cmd_valid, 1);
      chk("cmd_addr", cmd_addr, addr);
      chk("cmd_len", cmd_len, len);
      chk("cmd_rx_ready_off", rx_ready, 0);
      if (h < hold) @(negedge clk);
    end
    @(posedge clk);
    #1 cmd_ready = 1'b0;
    dma_ready = 1'b0;
  endtask

  task automatic send_data(input int nbeats, input int exp_last, input int rx_last_at,
                           input int seed, input bit toggle);
    int i = 1;
    int cyc = 0;
    while (i <= nbeats && cyc < 2000) begin
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = pat(seed, i);
      rx_keep  = kpat(seed, i);
      rx_last  = (i == rx_last_at);
      dma_ready = toggle ? ((cyc % 2) == 0) : 1'b1;
      cyc++;
      #1;
      chk("rx_ready_mirror", rx_ready, dma_ready);
      chk("dma_valid", dma_valid, 1);
      chk("dma_data", dma_data, pat(seed, i));
      chk("dma_keep", dma_keep, kpat(seed, i));
      chk("dma_last", dma_last, (i == exp_last));
      @(posedge clk);
      if (dma_ready) i++;
    end
    chk("data_beats_done", (i == nbeats + 1), 1);
    @(negedge clk);
    rx_valid = 1'b0; rx_last = 1'b0; dma_ready = 1'b0;
  endtask

  task automatic drain(input int nbeats, input int seed);
    for (int i = 1; i <= nbeats; i++) begin
      @(negedge clk);
      rx_valid = 1'b1;
      rx_last  = (i == nbeats);
      rx_data  = pat(seed, i);
      #1;
      chk("drain_rx_ready", rx_ready, 1);
      chk("drain_no_cmd", cmd_valid, 0);
      chk("drain_no_dma", dma_valid, 0);
      @(posedge clk);
    end
    @(negedge clk);
    rx_valid = 1'b0; rx_last = 1'b0;
  endtask

  initial begin
    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_meta_ready", meta_ready, 0);
    chk("rst_rx_ready", rx_ready, 0);
    chk("rst_cmd_valid", cmd_valid, 0);
    chk("rst_cmd_addr", cmd_addr, 0);
    chk("rst_cmd_len", cmd_len, 0);
    chk("rst_dma_valid", dma_valid, 0);
    chk("rst_dma_data", dma_data, 0);
    chk("rst_dma_last", dma_last, 0);
    chk("rst_stat_bytes", stat_bytes, 0);
    chk("rst_stat_pkts", stat_pkts, 0);
    chk("rst_stat_err", stat_err, 0);
    chk("rst_stat_done", stat_done, 0);
    @(negedge clk);
    rstn = 1'b1;
    dma_ready = 1'b1;
    @(negedge clk);
    chk("idle_meta_ready", meta_ready, 0);
    chk("idle_rx_ready", rx_ready, 0);
    dma_ready = 1'b0;

    // single packet, command held under back-pressure for 3 cycles
    start_run(64'h1000, 32'h10000, 32'd128);
    send_meta(16'd128);
    expect_cmd(64'h1000, 32'd128, 3);
    send_data(2, 2, 2, 1, 1'b0);
    chk("p1_bytes", stat_bytes, 128);
    chk("p1_pkts", stat_pkts, 1);
    chk("p1_done", stat_done, 1);
    chk("p1_done_meta_ready", meta_ready, 0);

    // restart to a new base; three 1500-byte packets wrap a 4096-byte ring
    start_run(64'h2_0000_0000, 32'd4096, 32'd4500);
    send_meta(16'd1500);
    expect_cmd(64'h2_0000_0000, 32'd1500, 0);
    send_data(24, 24, 24, 2, 1'b0);
    chk("w1_bytes", stat_bytes, 1500);
    send_meta(16'd1500);
    expect_cmd(64'h2_0000_0600, 32'd1500, 0);
    send_data(24, 24, 24, 3, 1'b0);
    send_meta(16'd1500);
    expect_cmd(64'h2_0000_0000, 32'd1500, 1);
    send_data(24, 24, 24, 4, 1'b0);
    chk("wrap_bytes", stat_bytes, 4500);
    chk("wrap_pkts", stat_pkts, 3);
    chk("wrap_done", stat_done, 1);

    // unaligned length, back-pressured max packet, length error, then normal packet
    start_run(64'h4000, 32'h10000, 32'd4260);
    send_meta(16'd100);
    expect_cmd(64'h4000, 32'd100, 0);
    send_data(2, 2, 2, 5, 1'b0);
    chk("u_bytes", stat_bytes, 100);
    chk("u_pkts", stat_pkts, 1);
    chk("u_done", stat_done, 0);
    send_meta(16'd4096);
    expect_cmd(64'h4080, 32'd4096, 0);
    send_data(64, 64, 64, 6, 1'b1);
    chk("bp_bytes", stat_bytes, 4196);
    chk("bp_pkts", stat_pkts, 2);
    send_meta(16'd0);
    drain(3, 7);
    chk("err_count", stat_err, 1);
    chk("err_bytes", stat_bytes, 4196);
    chk("err_pkts", stat_pkts, 2);
    send_meta(16'd64);
    expect_cmd(64'h5080, 32'd64, 0);
    send_data(1, 1, 1, 8, 1'b0);
    chk("post_err_bytes", stat_bytes, 4260);
    chk("post_err_pkts", stat_pkts, 3);
    chk("post_err_err", stat_err, 1);
    chk("post_err_done", stat_done, 1);

    // rx last missing on the final beat: counted as error, dma last still asserted
    start_run(64'h8000, 32'h10000, 32'd64);
    send_meta(16'd64);
    expect_cmd(64'h8000, 32'd64, 0);
    send_data(1, 1, 0, 9, 1'b0);
    chk("lastmis_err", stat_err, 1);
    chk("lastmis_bytes", stat_bytes, 64);
    chk("lastmis_done", stat_done, 1);

    // reset in the middle of a packet
    start_run(64'h9000, 32'h10000, 32'd1000);
    send_meta(16'd128);
    expect_cmd(64'h9000, 32'd128, 0);
    @(negedge clk);
    rx_valid = 1'b1; rx_data = pat(10, 1); rx_keep = kpat(10, 1); dma_ready = 1'b1;
    #1 chk("mid_dma_valid", dma_valid, 1);
    @(negedge clk);
    rstn = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_meta_ready", meta_ready, 0);
    chk("mid_rst_rx_ready", rx_ready, 0);
    chk("mid_rst_dma_valid", dma_valid, 0);
    chk("mid_rst_dma_data", dma_data, 0);
    chk("mid_rst_cmd_addr", cmd_addr, 0);
    chk("mid_rst_done", stat_done, 0);
    @(negedge clk);
    rx_valid = 1'b0; dma_ready = 1'b0; rstn = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
